// File: rtl/csi2_pkg.sv
// Shared CSI-2 definitions: data-type codes, parser state encoding, header ECC.
// Latency: n/a (types, constants and a pure function).
// Backpressure: n/a.
package csi2_pkg;

   localparam logic [5:0]  DT_FS       = 6'h00;
   localparam logic [5:0]  DT_FE       = 6'h01;
   localparam logic [5:0]  DT_LS       = 6'h02;
   localparam logic [5:0]  DT_LE       = 6'h03;
   localparam logic [5:0]  DT_RAW10    = 6'h2B;
   // Data types below this value are short packets (no payload, no CRC).
   localparam logic [5:0]  DT_LONG_MIN = 6'h10;
   localparam logic [15:0] CRC_INIT    = 16'hFFFF;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      HDR  = 2'd1,
      PAY  = 2'd2,
      CRC  = 2'd3
   } state_e;

   // CSI-2 6-bit Hamming parity over the 24 header bits {WC[15:0], DI[7:0]}.
   function automatic logic [5:0] csi2_ecc6(input logic [23:0] d);
      logic [5:0] p;
      p[0] = d[0]^d[1]^d[2]^d[4]^d[5]^d[7]^d[10]^d[11]^d[13]^d[16]^d[20]^d[21]^d[22]^d[23];
      p[1] = d[0]^d[1]^d[3]^d[4]^d[6]^d[8]^d[10]^d[12]^d[14]^d[17]^d[20]^d[21]^d[22]^d[23];
      p[2] = d[0]^d[2]^d[3]^d[5]^d[6]^d[9]^d[11]^d[12]^d[15]^d[18]^d[20]^d[21]^d[22];
      p[3] = d[1]^d[2]^d[3]^d[7]^d[8]^d[9]^d[13]^d[14]^d[15]^d[19]^d[20]^d[21]^d[23];
      p[4] = d[4]^d[5]^d[6]^d[7]^d[8]^d[9]^d[16]^d[17]^d[18]^d[19]^d[20]^d[22]^d[23];
      p[5] = d[10]^d[11]^d[12]^d[13]^d[14]^d[15]^d[16]^d[17]^d[18]^d[19]^d[21]^d[22]^d[23];
      return p;
   endfunction

endpackage

// File: rtl/csi2_pkt_parser_if.sv
// Bundle between the lane merger, the packet parser and the RAW10 unpacker.
// Latency: n/a (wiring only).
// Backpressure: none; in_vld low is a stall, there is no ready.
// Signals: in_vld/in_sop/in_data (byte stream in), raw_vld/raw_data/raw_vsync (pixel side),
//          line_start/frame_end/frame_num (framing), err_ecc/err_crc/err_wc/err_trunc (status).
interface csi2_pkt_parser_if;
   logic        in_vld;
   logic        in_sop;
   logic [15:0] in_data;
   logic        raw_vld;
   logic [15:0] raw_data;
   logic        raw_vsync;
   logic        line_start;
   logic        frame_end;
   logic [15:0] frame_num;
   logic        err_ecc;
   logic        err_crc;
   logic        err_wc;
   logic        err_trunc;

   // Upstream side: drives the byte stream, observes parser outputs.
   modport master (
      output in_vld, in_sop, in_data,
      input  raw_vld, raw_data, raw_vsync, line_start, frame_end, frame_num,
      input  err_ecc, err_crc, err_wc, err_trunc
   );

   // Parser side.
   modport slave (
      input  in_vld, in_sop, in_data,
      output raw_vld, raw_data, raw_vsync, line_start, frame_end, frame_num,
      output err_ecc, err_crc, err_wc, err_trunc
   );
endinterface

// File: rtl/csi2_crc16_x2.sv
// Next-state of the CSI-2 payload CRC-16 after two bytes (data[7:0] first, each LSB-first).
// Latency: combinational.
// Backpressure: n/a; the caller decides when to register crc_nxt.
// Ports: crc = current CRC, data = payload word, crc_nxt = CRC after both bytes.
module csi2_crc16_x2 (
   input  logic [15:0] crc,
   input  logic [15:0] data,
   output logic [15:0] crc_nxt
);

   logic [15:0] c_v;
   logic        fb_v;

   // Reflected form of x^16+x^12+x^5+1: shifting right and XORing 0x8408
   // processes bits LSB-first, which is the CSI-2 wire order.
   always_comb begin
      c_v  = crc;
      fb_v = 1'b0;
      for (int i = 0; i < 16; i++) begin
         fb_v = c_v[0] ^ data[i];
         c_v  = {1'b0, c_v[15:1]} ^ (fb_v ? 16'h8408 : 16'h0000);
      end
      crc_nxt = c_v;
   end

endmodule

// File: rtl/csi2_pkt_parser.sv
// CSI-2 2-lane packet parser: decodes headers, forwards RAW10 payload on VC_SEL, checks ECC/CRC.
// Latency: every output is registered, 1 clk after the in_vld word that causes it.
// Backpressure: none; in_vld low stalls all state and produces no pulses.
// Ports: clk, reset (sync, active-high); bus (slave) carries in_* stream and all outputs.
module csi2_pkt_parser #(
   parameter logic [1:0] VC_SEL   = 2'd0,
   parameter logic [5:0] DT_RAW10 = 6'h2B
) (
   input logic              clk,
   input logic              reset,
   csi2_pkt_parser_if.slave bus
);
   import csi2_pkg::*;

   state_e      state_q, state_d;
   logic [15:0] word0_q, word0_d;
   logic [16:0] cnt_q, cnt_d;
   logic        fwd_q, fwd_d;
   logic [15:0] crc_q, crc_d;
   logic [15:0] crc_nxt;

   logic        raw_vld_q, raw_vld_d;
   logic [15:0] raw_data_q, raw_data_d;
   logic        raw_vsync_q, raw_vsync_d;
   logic        line_start_q, line_start_d;
   logic        frame_end_q, frame_end_d;
   logic [15:0] frame_num_q, frame_num_d;
   logic        err_ecc_q, err_ecc_d;
   logic        err_crc_q, err_crc_d;
   logic        err_wc_q, err_wc_d;
   logic        err_trunc_q, err_trunc_d;

   // Header fields: word0 was latched on SOP, the current in_data is word1.
   logic [7:0]  di;
   logic [1:0]  vc;
   logic [5:0]  dt;
   logic [15:0] wc;
   logic        ecc_ok;
   logic        raw_sel;
   logic        wc_ok;

   assign di      = word0_q[7:0];
   assign vc      = di[7:6];
   assign dt      = di[5:0];
   assign wc      = {bus.in_data[7:0], word0_q[15:8]};
   assign ecc_ok  = (bus.in_data[15:8] == {2'b00, csi2_ecc6({wc, di})});
   assign raw_sel = (vc == VC_SEL) && (dt == DT_RAW10);
   // RAW10 packs 4 pixels in 5 bytes; 2 bytes/clk means a whole line must be a multiple of 10.
   assign wc_ok   = (wc != 16'd0) && ((wc % 16'd10) == 16'd0);

   csi2_crc16_x2 u_crc (
      .crc     (crc_q),
      .data    (bus.in_data),
      .crc_nxt (crc_nxt)
   );

   always_comb begin
      state_d      = state_q;
      word0_d      = word0_q;
      cnt_d        = cnt_q;
      fwd_d        = fwd_q;
      crc_d        = crc_q;
      raw_vld_d    = 1'b0;
      raw_data_d   = raw_data_q;
      raw_vsync_d  = 1'b0;
      line_start_d = 1'b0;
      frame_end_d  = 1'b0;
      frame_num_d  = frame_num_q;
      err_ecc_d    = 1'b0;
      err_crc_d    = 1'b0;
      err_wc_d     = 1'b0;
      err_trunc_d  = 1'b0;

      if (bus.in_vld) begin
         if (bus.in_sop) begin
            // A new packet always wins; anything in flight is abandoned.
            err_trunc_d = (state_q != IDLE);
            word0_d     = bus.in_data;
            state_d     = HDR;
         end else begin
            case (state_q)
               IDLE: state_d = IDLE;
               HDR: begin
                  crc_d = CRC_INIT;
                  fwd_d = 1'b0;
                  if (!ecc_ok) begin
                     err_ecc_d = 1'b1;
                     state_d   = IDLE;
                  end else if (dt < DT_LONG_MIN) begin
                     state_d = IDLE;
                     if (vc == VC_SEL) begin
                        if (dt == DT_FS) begin
                           raw_vsync_d = 1'b1;
                           frame_num_d = wc;
                        end
                        frame_end_d = (dt == DT_FE);
                     end
                  end else begin
                     fwd_d        = raw_sel && wc_ok;
                     line_start_d = raw_sel && wc_ok;
                     err_wc_d     = raw_sel && !wc_ok;
                     // Discarded packets also swallow the CRC word, hence +2 bytes.
                     cnt_d        = (raw_sel && wc_ok) ? {2'b00, wc[15:1]}
                                                       : (({1'b0, wc} + 17'd3) >> 1);
                     state_d      = PAY;
                  end
               end
               PAY: begin
                  if (fwd_q) begin
                     raw_vld_d  = 1'b1;
                     raw_data_d = bus.in_data;
                     crc_d      = crc_nxt;
                  end
                  cnt_d = cnt_q - 17'd1;
                  if (cnt_q == 17'd1) begin
                     state_d = fwd_q ? CRC : IDLE;
                  end
               end
               CRC: begin
                  err_crc_d = (bus.in_data != crc_q);
                  state_d   = IDLE;
               end
               default: state_d = IDLE;
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q      <= IDLE;
         word0_q      <= 16'h0000;
         cnt_q        <= 17'd0;
         fwd_q        <= 1'b0;
         crc_q        <= CRC_INIT;
         raw_vld_q    <= 1'b0;
         raw_data_q   <= 16'h0000;
         raw_vsync_q  <= 1'b0;
         line_start_q <= 1'b0;
         frame_end_q  <= 1'b0;
         frame_num_q  <= 16'h0000;
         err_ecc_q    <= 1'b0;
         err_crc_q    <= 1'b0;
         err_wc_q     <= 1'b0;
         err_trunc_q  <= 1'b0;
      end else begin
         state_q      <= state_d;
         word0_q      <= word0_d;
         cnt_q        <= cnt_d;
         fwd_q        <= fwd_d;
         crc_q        <= crc_d;
         raw_vld_q    <= raw_vld_d;
         raw_data_q   <= raw_data_d;
         raw_vsync_q  <= raw_vsync_d;
         line_start_q <= line_start_d;
         frame_end_q  <= frame_end_d;
         frame_num_q  <= frame_num_d;
         err_ecc_q    <= err_ecc_d;
         err_crc_q    <= err_crc_d;
         err_wc_q     <= err_wc_d;
         err_trunc_q  <= err_trunc_d;
      end
   end

   assign bus.raw_vld    = raw_vld_q;
   assign bus.raw_data   = raw_data_q;
   assign bus.raw_vsync  = raw_vsync_q;
   assign bus.line_start = line_start_q;
   assign bus.frame_end  = frame_end_q;
   assign bus.frame_num  = frame_num_q;
   assign bus.err_ecc    = err_ecc_q;
   assign bus.err_crc    = err_crc_q;
   assign bus.err_wc     = err_wc_q;
   assign bus.err_trunc  = err_trunc_q;

endmodule

// File: tb/tb_csi2_pkt_parser.sv
// Directed bench for csi2_pkt_parser: one table row per clock, plus a reset-mid-packet sequence.
// Latency: expects each effect 1 clk after the word that causes it.
// Backpressure: exercises in_vld gaps inside payload.
module tb_csi2_pkt_parser;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   csi2_pkt_parser_if bus();

   csi2_pkt_parser #(.VC_SEL(2'd0), .DT_RAW10(6'h2B)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   // Flag vector order: {raw_vsync, line_start, frame_end, err_ecc, err_crc, err_wc, err_trunc}
   localparam logic [6:0] F_NONE = 7'h00;
   localparam logic [6:0] F_VS   = 7'h40;
   localparam logic [6:0] F_LS   = 7'h20;
   localparam logic [6:0] F_FE   = 7'h10;
   localparam logic [6:0] F_ECC  = 7'h08;
   localparam logic [6:0] F_CRC  = 7'h04;
   localparam logic [6:0] F_WC   = 7'h02;
   localparam logic [6:0] F_TR   = 7'h01;

   // Hamming column code of each header bit, D23 first.
   localparam logic [143:0] ECC_COLS = {
      6'h3B, 6'h37, 6'h2F, 6'h1F, 6'h38, 6'h34, 6'h32, 6'h31,
      6'h2C, 6'h2A, 6'h29, 6'h26, 6'h25, 6'h23, 6'h1C, 6'h1A,
      6'h19, 6'h16, 6'h15, 6'h13, 6'h0E, 6'h0D, 6'h0B, 6'h07};

   typedef struct {
      string       tag;
      bit          rst;
      bit          vld;
      bit          sop;
      logic [15:0] dat;
      bit          e_rvld;
      logic [6:0]  e_flg;
      logic [15:0] e_fnum;
   } vec_t;

   vec_t        vecs[$];
   int          n_vec  = 0;
   int          n_bad  = 0;
   logic [15:0] fnum_m = 16'h0000;

   function automatic logic [5:0] ecc_tb(input logic [23:0] d);
      logic [143:0] cols;
      logic [5:0]   e;
      cols = ECC_COLS;
      e    = 6'h00;
      for (int i = 0; i < 24; i++)
         if (d[i]) e = e ^ cols[i*6 +: 6];
      return e;
   endfunction

   function automatic logic [15:0] rev16(input logic [15:0] x);
      logic [15:0] r;
      for (int i = 0; i < 16; i++) r[i] = x[15-i];
      return r;
   endfunction

   // Forward (MSB-first) CCITT register on bit-reversed state; equivalent to the LSB-first wire CRC.
   function automatic logic [15:0] crc_tb(input logic [15:0] crc, input logic [15:0] d);
      logic [15:0] r;
      logic        fb;
      r = rev16(crc);
      for (int i = 0; i < 16; i++) begin
         fb = r[15] ^ d[i];
         r  = {r[14:0], 1'b0};
         if (fb) r = r ^ 16'h1021;
      end
      return rev16(r);
   endfunction

   function automatic logic [15:0] hw0(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
      return {wc[7:0], vc, dt};
   endfunction

   function automatic logic [15:0] hw1(input logic [1:0] vc, input logic [5:0] dt, input logic [15:0] wc);
      return {2'b00, ecc_tb({wc, vc, dt}), wc[15:8]};
   endfunction

   function automatic void add(input string tag, input bit rst, input bit vld, input bit sop,
                               input logic [15:0] dat, input bit e_rvld, input logic [6:0] flg);
      vec_t v;
      v.tag = tag; v.rst = rst; v.vld = vld; v.sop = sop; v.dat = dat;
      v.e_rvld = e_rvld; v.e_flg = flg; v.e_fnum = fnum_m;
      vecs.push_back(v);
   endfunction

   function automatic void short_pkt(input string tag, input logic [1:0] vc, input logic [5:0] dt,
                                     input logic [15:0] wc, input logic [7:0] ecc_x,
                                     input logic [6:0] flg, input bit upd_fnum);
      add(tag, 0, 1, 1, hw0(vc, dt, wc), 0, F_NONE);
      if (upd_fnum) fnum_m = wc;
      add(tag, 0, 1, 0, hw1(vc, dt, wc) ^ {ecc_x, 8'h00}, 0, flg);
   endfunction

   function automatic void long_pkt(input string tag, input logic [1:0] vc, input logic [5:0] dt,
                                    input logic [15:0] wc, input bit fwd, input logic [6:0] hflg,
                                    input logic [15:0] crc_flip);
      logic [15:0] crc;
      logic [15:0] w;
      int          n;
      add(tag, 0, 1, 1, hw0(vc, dt, wc), 0, F_NONE);
      add(tag, 0, 1, 0, hw1(vc, dt, wc), 0, hflg);
      crc = 16'hFFFF;
      n   = fwd ? int'(wc) / 2 : (int'(wc) + 3) / 2;
      for (int k = 0; k < n; k++) begin
         w = {8'(2*k + 2), 8'(2*k + 1)};
         if (fwd) crc = crc_tb(crc, w);
         add(tag, 0, 1, 0, w, fwd, F_NONE);
      end
      if (fwd) add(tag, 0, 1, 0, crc ^ crc_flip, 0, (crc_flip != 16'h0) ? F_CRC : F_NONE);
   endfunction

   task automatic step(input string tag, input bit rst, input bit vld, input bit sop,
                       input logic [15:0] dat, input bit e_rvld, input logic [6:0] e_flg,
                       input logic [15:0] e_fnum);
      logic [6:0]  flg;
      logic [15:0] rdat;
      logic [15:0] e_rdat;
      reset       = rst;
      bus.in_vld  = vld;
      bus.in_sop  = sop;
      bus.in_data = dat;
      @(posedge clk);
      #1;
      flg    = {bus.raw_vsync, bus.line_start, bus.frame_end, bus.err_ecc,
                bus.err_crc, bus.err_wc, bus.err_trunc};
      rdat   = bus.raw_vld ? bus.raw_data : 16'h0000;
      e_rdat = e_rvld ? dat : 16'h0000;
      n_vec++;
      if (bus.raw_vld !== e_rvld || rdat !== e_rdat || flg !== e_flg || bus.frame_num !== e_fnum) begin
         n_bad++;
         $display("FAIL %s: got raw_vld=%b raw_data=%h flags=%b frame_num=%0d, want raw_vld=%b raw_data=%h flags=%b frame_num=%0d",
                  tag, bus.raw_vld, rdat, flg, bus.frame_num, e_rvld, e_rdat, e_flg, e_fnum);
      end
   endtask

   initial begin
      reset       = 1'b1;
      bus.in_vld  = 1'b0;
      bus.in_sop  = 1'b0;
      bus.in_data = 16'h0000;

      add("reset", 1, 0, 0, 16'h0000, 0, F_NONE);
      add("reset", 1, 1, 1, 16'hFFFF, 0, F_NONE);
      add("idle_junk", 0, 1, 0, 16'h1234, 0, F_NONE);
      short_pkt("fs5", 2'd0, 6'h00, 16'd5, 8'h00, F_VS, 1);
      long_pkt("raw_ok", 2'd0, 6'h2B, 16'd10, 1, F_LS, 16'h0000);
      long_pkt("raw_badcrc", 2'd0, 6'h2B, 16'd10, 1, F_LS, 16'h0001);
      short_pkt("fs6_badecc", 2'd0, 6'h00, 16'd6, 8'h04, F_ECC, 0);
      short_pkt("fs7", 2'd0, 6'h00, 16'd7, 8'h00, F_VS, 1);
      short_pkt("fe_vc0", 2'd0, 6'h01, 16'd7, 8'h00, F_FE, 0);
      short_pkt("fe_vc1", 2'd1, 6'h01, 16'd7, 8'h00, F_NONE, 0);
      short_pkt("ls_vc0", 2'd0, 6'h02, 16'd1, 8'h00, F_NONE, 0);
      long_pkt("raw_wc12", 2'd0, 6'h2B, 16'd12, 0, F_WC, 16'h0000);
      long_pkt("raw_vc1", 2'd1, 6'h2B, 16'd10, 0, F_NONE, 16'h0000);
      long_pkt("raw_wc0", 2'd0, 6'h2B, 16'd0, 0, F_WC, 16'h0000);
      long_pkt("raw8_wc5", 2'd0, 6'h2A, 16'd5, 0, F_NONE, 16'h0000);
      short_pkt("fs8", 2'd0, 6'h00, 16'd8, 8'h00, F_VS, 1);
      // Truncation: WC=20 packet cut by SOP on its 3rd payload word, with a stall in between.
      add("trunc_h0", 0, 1, 1, hw0(2'd0, 6'h2B, 16'd20), 0, F_NONE);
      add("trunc_h1", 0, 1, 0, hw1(2'd0, 6'h2B, 16'd20), 0, F_LS);
      add("trunc_p0", 0, 1, 0, 16'h0201, 1, F_NONE);
      add("trunc_gap", 0, 0, 0, 16'hDEAD, 0, F_NONE);
      add("trunc_p1", 0, 1, 0, 16'h0403, 1, F_NONE);
      add("trunc_sop", 0, 1, 1, hw0(2'd0, 6'h00, 16'd9), 0, F_TR);
      fnum_m = 16'd9;
      add("trunc_fs9", 0, 1, 0, hw1(2'd0, 6'h00, 16'd9), 0, F_VS);
      long_pkt("raw_after", 2'd0, 6'h2B, 16'd20, 1, F_LS, 16'h0000);

      foreach (vecs[i])
         step(vecs[i].tag, vecs[i].rst, vecs[i].vld, vecs[i].sop, vecs[i].dat,
              vecs[i].e_rvld, vecs[i].e_flg, vecs[i].e_fnum);

      // Synchronous reset in the middle of a forwarded payload.
      step("mp_h0", 0, 1, 1, hw0(2'd0, 6'h2B, 16'd10), 0, F_NONE, fnum_m);
      step("mp_h1", 0, 1, 0, hw1(2'd0, 6'h2B, 16'd10), 0, F_LS, fnum_m);
      step("mp_p0", 0, 1, 0, 16'h0201, 1, F_NONE, fnum_m);
      step("mp_rst", 1, 1, 0, 16'h0403, 0, F_NONE, 16'd0);
      step("mp_idle", 0, 1, 0, 16'h0605, 0, F_NONE, 16'd0);
      step("mp_fs0", 0, 1, 1, hw0(2'd0, 6'h00, 16'd3), 0, F_NONE, 16'd0);
      step("mp_fs1", 0, 1, 0, hw1(2'd0, 6'h00, 16'd3), 0, F_VS, 16'd3);
      step("mp_quiet", 0, 0, 0, 16'h0000, 0, F_NONE, 16'd3);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
